hdmi_timing_gen: RTL and testbench
==================================

HDMI_TIMING_GEN -- requirements
Module: hdmi_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280: active pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 110, 40, 220: horizontal front porch, sync width and back porch, in clocks.
REQ-003 SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 720, 5, 5, 20: the vertical equivalents, in lines.
REQ-004 SHALL have parameters H_POL and V_POL, default 1: sync polarity (1 = active-high pulse).
REQ-005 SHALL have parameter COLOR_W, default 8: bits per colour component.
REQ-006 SHALL have the following ports:
- clk_i  in  1: pixel clock; one clock only.
- rst_i  in  1: reset; synchronous, active-high.
- en_i  in  1: timing enable.
- mode_i  in  2: pattern select.
- pix_data_i  in  3*COLOR_W: external pixel, {R,G,B}.
- pix_valid_i  in  1: external pixel valid.
- pix_ready_o  out  1: external pixel accepted.
- hsync_o  out  1: horizontal sync.
- vsync_o  out  1: vertical sync.
- de_o  out  1: data enable.
- data_o  out  3*COLOR_W: pixel data.
- sof_o  out  1: start-of-frame strobe.
- underflow_o  out  1: starvation strobe.
- frame_cnt_o  out  16: completed-frame count.

Function
REQ-007 SHALL derive H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL likewise; counter widths SHALL be $clog2 of the totals.
REQ-008 SHALL keep h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1). When en_i=1, h_cnt SHALL advance every clock; at H_TOTAL-1 it SHALL wrap to 0 and advance v_cnt. v_cnt SHALL wrap to 0 after V_TOTAL-1.
REQ-009 Line and frame order SHALL be sync, back porch, active, front porch. Active is h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
REQ-010 On each edge with en_i=1, outputs SHALL register the decode of the current (h_cnt, v_cnt) before the counters advance:
- hsync_o=H_POL when h_cnt<H_SYNC, else ~H_POL.
- vsync_o=V_POL when v_cnt<V_SYNC, else ~V_POL.
- de_o=1 inside the active region.
REQ-011 On an edge with en_i=0, counters SHALL return to (0,0) and outputs SHALL go idle: syncs at ~POL, de_o=0, sof_o=0, underflow_o=0. data_o SHALL hold. Deassertion mid-frame SHALL abort the frame immediately.
REQ-012 mode_i SHALL be sampled only when en_i=1 and (h_cnt,v_cnt)=(0,0), and held for the whole frame. Modes:
- 0: external stream.
- 1: colour bars.
- 2: gradient.
- 3: black.
REQ-013 pix_ready_o SHALL be combinational: en_i & active region & latched mode 0. A beat SHALL transfer on an edge with pix_ready_o & pix_valid_i, and data_o SHALL load pix_data_i on that same edge.
REQ-014 If pix_ready_o=1 and pix_valid_i=0: de_o SHALL still assert, data_o SHALL load 0, and underflow_o SHALL pulse for 1 cycle. Timing SHALL never stall.
REQ-015 sof_o SHALL pulse for 1 cycle together with de_o for the first active pixel of each frame.
REQ-016 frame_cnt_o SHALL increment, wrapping at 16 bits, on the edge where (h_cnt,v_cnt)=(H_TOTAL-1,V_TOTAL-1) with en_i=1.
REQ-017 Outside the active region, data_o SHALL hold its last value.

Reset
REQ-018 When rst_i=1 at an edge, the block SHALL clear:
- counters to (0,0);
- frame_cnt_o to 0;
- data_o to 0;
- de_o, sof_o, underflow_o to 0;
- hsync_o to ~H_POL and vsync_o to ~V_POL;
- latched mode to 0.
rst_i SHALL take priority over en_i.
REQ-019 Reset mid-frame SHALL abort the frame. The first edge with rst_i=0 and en_i=1 SHALL decode position (0,0).

Configuration
REQ-020 Macro HDMI_TIMING_GEN_TEST_PATTERN_EN SHALL compile in modes 1–3.
- Colour bars: eight bars, each BAR_W=H_ACTIVE/8 pixels wide. Order is white, yellow, cyan, green, magenta, red, blue, black. Components are all-ones or 0. Any remainder pixels SHALL extend the black bar.
- Gradient: a 3*COLOR_W counter output as data_o. It SHALL increment after each active pixel and clear at frame start.
REQ-021 Without the macro, mode_i SHALL be ignored and the latched mode SHALL always be 0 (external).

Verification
Bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=4 (H_TOTAL=25); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); COLOR_W=8; polarity 1 unless stated.
REQ-022 Reset, then en_i=1 held, mode 0, valid always 1:
- hsync_o is 1 for 3 of every 25 cycles.
- vsync_o is 1 for 50 cycles per 200.
- de_o gives 16-cycle bursts on 4 lines per frame.
- sof_o pulses every 200 cycles.
- frame_cnt_o=1 after 200 cycles.
REQ-023 Mode 0 with pix_valid_i dropped for pixel 5 of line 0 -> that pixel has data_o=0, underflow_o pulses once, and de_o is unbroken.
REQ-024 Macro defined, mode_i=1 -> each active line gives data_o pairs FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-025 Macro defined, mode_i=2 -> frame 0 pixels run 000000..00003F over 64 pixels and restart at 000000 in frame 1. mode_i changed mid-frame -> no effect until the next frame.
REQ-026 H_POL=V_POL=0, en_i dropped at cycle 100 -> next edge hsync_o=vsync_o=1 and de_o=0. Re-enable -> the sequence restarts from position (0,0).
REQ-027 rst_i pulsed mid-active-line -> all outputs take their reset values on that edge, and frame_cnt_o=0.

Source files
------------

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: HDMI/DVI raster timing with an external-stream or test-pattern pixel source; HDMI_TIMING_GEN_TEST_PATTERN_EN enables bars/gradient/black modes.
// Latency: syncs/de/data register the decode of the current raster position one clock later; pix_ready_o is combinational.
// Backpressure: none, timing never stalls; a missing external pixel in active video outputs 0 and pulses underflow_o.
module hdmi_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1,
  parameter int COLOR_W  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [1:0]           mode_i,
  input  logic [3*COLOR_W-1:0] pix_data_i,
  input  logic                 pix_valid_i,
  output logic                 pix_ready_o,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 de_o,
  output logic [3*COLOR_W-1:0] data_o,
  output logic                 sof_o,
  output logic                 underflow_o,
  output logic [15:0]          frame_cnt_o
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = 3 * COLOR_W;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_W   = HW'(H_SYNC);
  localparam logic [VW-1:0] V_SYNC_W   = VW'(V_SYNC);
  localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic          HPOL       = (H_POL != 0);
  localparam logic          VPOL       = (V_POL != 0);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [1:0]    mode_q;
  logic          h_act;
  logic          v_act;
  logic          active;
  logic          frame_start;
  logic          first_pix;
  logic          starve;
  logic [DW-1:0] pattern_dat;
  logic [DW-1:0] pix_nxt;

  always_comb begin
    h_act       = (h_cnt >= H_ACT_BEG) && (h_cnt <= H_ACT_LAST);
    v_act       = (v_cnt >= V_ACT_BEG) && (v_cnt <= V_ACT_LAST);
    active      = h_act && v_act;
    frame_start = (h_cnt == '0) && (v_cnt == '0);
    first_pix   = active && (h_cnt == H_ACT_BEG) && (v_cnt == V_ACT_BEG);
  end

  assign pix_ready_o = en_i && active && (mode_q == 2'd0);

`ifdef HDMI_TIMING_GEN_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [DW-1:0] grad_q;
  logic [31:0]   bar_num;
  logic [2:0]    bar_idx;

  // Remainder pixels past the eighth bar clamp to index 7, i.e. black.
  always_comb begin
    bar_num = 32'(h_cnt - H_ACT_BEG) / 32'(BAR_W);
    bar_idx = (bar_num >= 32'd7) ? 3'd7 : bar_num[2:0];
    unique case (mode_q)
      2'd1:    pattern_dat = {{COLOR_W{~bar_idx[1]}}, {COLOR_W{~bar_idx[2]}}, {COLOR_W{~bar_idx[0]}}};
      2'd2:    pattern_dat = grad_q;
      default: pattern_dat = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= 2'd0;
      grad_q <= '0;
    end else if (en_i) begin
      if (frame_start) begin
        mode_q <= mode_i;
        grad_q <= '0;
      end else if (active) begin
        grad_q <= grad_q + DW'(1);
      end
    end
  end
`else
  logic unused_mode;

  assign unused_mode = ^mode_i;
  assign mode_q      = 2'd0;
  assign pattern_dat = '0;
`endif

  always_comb begin
    pix_nxt = pattern_dat;
    starve  = 1'b0;
    if (mode_q == 2'd0) begin
      if (pix_valid_i) begin
        pix_nxt = pix_data_i;
      end else begin
        pix_nxt = '0;
        starve  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync_o     <= ~HPOL;
      vsync_o     <= ~VPOL;
      de_o        <= 1'b0;
      sof_o       <= 1'b0;
      underflow_o <= 1'b0;
      data_o      <= '0;
      frame_cnt_o <= 16'd0;
    end else if (!en_i) begin
      // Disable aborts the frame; data_o keeps its last pixel.
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync_o     <= ~HPOL;
      vsync_o     <= ~VPOL;
      de_o        <= 1'b0;
      sof_o       <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      hsync_o     <= (h_cnt < H_SYNC_W) ? HPOL : ~HPOL;
      vsync_o     <= (v_cnt < V_SYNC_W) ? VPOL : ~VPOL;
      de_o        <= active;
      sof_o       <= first_pix;
      underflow_o <= active && starve;
      if (active) begin
        data_o <= pix_nxt;
      end
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt       <= '0;
          frame_cnt_o <= frame_cnt_o + 16'd1;
        end else begin
          v_cnt <= v_cnt + VW'(1);
        end
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen: small raster, one active-high and one active-low instance, checked against a position-based reference model.
module tb_hdmi_timing_gen;
  localparam int HA = 16, HFP = 2, HS = 3, HB = 4;
  localparam int VA = 4, VFP = 1, VS = 2, VB = 1;
  localparam int CW = 8, DW = 3 * CW;
  localparam int HT = HS + HB + HA + HFP;
  localparam int VT = VS + VB + VA + VFP;
  localparam int FT = HT * VT;
  localparam int HBEG = HS + HB, VBEG = VS + VB;
`ifdef HDMI_TIMING_GEN_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b0, en = 1'b0, valid = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] pix = '0;
  logic          ready, hs, vs, de, sof, uf;
  logic [DW-1:0] data;
  logic [15:0]   fcnt;
  logic          n_ready, n_hs, n_vs, n_de, n_sof, n_uf;
  logic [DW-1:0] n_data;
  logic [15:0]   n_fcnt;
  int            errors = 0, checks = 0;

  // Reference model: raster position as a frame-relative cycle index.
  int            k = 0, frames = 0;
  logic [1:0]    fmode = 2'd0;
  logic          e_hs = 1'b0, e_vs = 1'b0, e_de = 1'b0, e_sof = 1'b0, e_uf = 1'b0;
  logic [DW-1:0] e_data = '0;
  logic [DW-1:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  hdmi_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VFP),
                    .V_SYNC(VS), .V_BP(VB), .H_POL(1), .V_POL(1), .COLOR_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .pix_data_i(pix), .pix_valid_i(valid),
    .pix_ready_o(ready), .hsync_o(hs), .vsync_o(vs), .de_o(de), .data_o(data), .sof_o(sof),
    .underflow_o(uf), .frame_cnt_o(fcnt));

  hdmi_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VFP),
                    .V_SYNC(VS), .V_BP(VB), .H_POL(0), .V_POL(0), .COLOR_W(CW)) dut_n (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .pix_data_i(pix), .pix_valid_i(valid),
    .pix_ready_o(n_ready), .hsync_o(n_hs), .vsync_o(n_vs), .de_o(n_de), .data_o(n_data), .sof_o(n_sof),
    .underflow_o(n_uf), .frame_cnt_o(n_fcnt));

  always #5 clk = ~clk;

  function automatic bit in_active(int p);
    int h = p % HT;
    int v = p / HT;
    return (h >= HBEG) && (h < HBEG + HA) && (v >= VBEG) && (v < VBEG + VA);
  endfunction

  task automatic model_edge();
    int h, v, x, y, b;
    if (rst) begin
      k = 0; frames = 0; fmode = 2'd0; e_data = '0;
      e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_sof = 1'b0; e_uf = 1'b0;
      return;
    end
    if (!en) begin
      k = 0; e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_sof = 1'b0; e_uf = 1'b0;
      return;
    end
    h = k % HT; v = k / HT;
    if (k == 0) fmode = PAT ? mode : 2'd0;
    e_hs  = (h < HS);
    e_vs  = (v < VS);
    e_de  = in_active(k);
    e_sof = e_de && (h == HBEG) && (v == VBEG);
    e_uf  = 1'b0;
    if (e_de) begin
      x = h - HBEG; y = v - VBEG;
      case (fmode)
        2'd0: begin
          e_data = valid ? pix : '0;
          e_uf   = !valid;
        end
        2'd1: begin
          b = x / (HA / 8);
          e_data = bars[(b > 7) ? 7 : b];
        end
        2'd2: e_data = DW'(y * HA + x);
        default: e_data = '0;
      endcase
    end
    if (k == FT - 1) frames++;
    k = (k + 1) % FT;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    tick(); tick();
    checks++; if (hs !== 1'b0 || vs !== 1'b0) begin errors++; $display("FAIL reset_sync_pos got %b%b want 00", hs, vs); end
    checks++; if (n_hs !== 1'b1 || n_vs !== 1'b1) begin errors++; $display("FAIL reset_sync_neg got %b%b want 11", n_hs, n_vs); end
    checks++; if ({de, sof, uf} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b want 000", {de, sof, uf}); end
    checks++; if (data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", data); end
    checks++; if (fcnt !== 16'd0) begin errors++; $display("FAIL reset_fcnt got %0d want 0", fcnt); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int c_hs = 0, c_vs = 0, c_de = 0, c_sof = 0, run = 0;
    logic prev_de = 1'b0;
    en = 1'b1; mode = 2'd0; valid = 1'b1;
    for (int i = 0; i < FT; i++) begin
      pix = DW'($urandom);
      checks++; if (ready !== (in_active(k) && fmode == 2'd0)) begin errors++; $display("FAIL stream_ready k=%0d got %b", k, ready); end
      tick();
      checks++;
      if ({hs, vs, de, sof, uf} !== {e_hs, e_vs, e_de, e_sof, e_uf}) begin
        errors++; $display("FAIL stream_ctl k=%0d got %b want %b", k, {hs, vs, de, sof, uf}, {e_hs, e_vs, e_de, e_sof, e_uf});
      end
      checks++; if (data !== e_data) begin errors++; $display("FAIL stream_data k=%0d got %h want %h", k, data, e_data); end
      checks++; if (fcnt !== 16'(frames)) begin errors++; $display("FAIL stream_fcnt k=%0d got %0d want %0d", k, fcnt, frames); end
      c_hs += int'(hs); c_vs += int'(vs); c_de += int'(de); c_sof += int'(sof);
      if (de) run++;
      if (prev_de && !de) begin
        checks++; if (run != HA) begin errors++; $display("FAIL stream_burst got %0d want %0d", run, HA); end
        run = 0;
      end
      prev_de = de;
    end
    checks++; if (c_hs != 24) begin errors++; $display("FAIL stream_hs_count got %0d want 24", c_hs); end
    checks++; if (c_vs != 50) begin errors++; $display("FAIL stream_vs_count got %0d want 50", c_vs); end
    checks++; if (c_de != 64) begin errors++; $display("FAIL stream_de_count got %0d want 64", c_de); end
    checks++; if (c_sof != 1) begin errors++; $display("FAIL stream_sof_count got %0d want 1", c_sof); end
    checks++; if (fcnt !== 16'd1) begin errors++; $display("FAIL stream_frame_one got %0d want 1", fcnt); end
  endtask

  task automatic test_underflow();
    int c_uf = 0, c_de = 0;
    int drop_k = VBEG * HT + HBEG + 5;
    en = 1'b1; mode = 2'd0;
    for (int i = 0; i < 2 * FT; i++) begin
      pix = DW'($urandom);
      if (i < FT) valid = (k != drop_k);
      else        valid = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if ({de, uf} !== {e_de, e_uf} || data !== e_data) begin
        errors++; $display("FAIL underflow_cycle i=%0d got de=%b uf=%b d=%h want de=%b uf=%b d=%h", i, de, uf, data, e_de, e_uf, e_data);
      end
      if (i < FT) begin
        c_uf += int'(uf); c_de += int'(de);
        if (i == drop_k) begin
          checks++; if (data !== '0 || uf !== 1'b1) begin errors++; $display("FAIL underflow_pixel5 got d=%h uf=%b want 0 1", data, uf); end
        end
      end
    end
    checks++; if (c_uf != 1) begin errors++; $display("FAIL underflow_pulses got %0d want 1", c_uf); end
    checks++; if (c_de != 64) begin errors++; $display("FAIL underflow_de_count got %0d want 64", c_de); end
  endtask

  task automatic test_patterns();
    logic [1:0] plan [5] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
    en = 1'b1;
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < FT; i++) begin
        mode  = (k == 0) ? plan[f] : 2'($urandom_range(0, 3));
        pix   = DW'($urandom);
        valid = ($urandom_range(0, 4) != 0);
        checks++; if (ready !== (in_active(k) && fmode == 2'd0)) begin errors++; $display("FAIL pattern_ready f=%0d k=%0d got %b", f, k, ready); end
        tick();
        checks++;
        if ({de, sof, uf} !== {e_de, e_sof, e_uf} || data !== e_data) begin
          errors++; $display("FAIL pattern_cycle f=%0d i=%0d got de=%b sof=%b uf=%b d=%h want %b %b %b %h",
                             f, i, de, sof, uf, data, e_de, e_sof, e_uf, e_data);
        end
      end
    end
  endtask

  task automatic test_disable();
    logic [DW-1:0] held;
    en = 1'b1; mode = 2'd0; valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      pix = DW'($urandom);
      tick();
      checks++;
      if ({n_hs, n_vs, n_de, n_sof} !== {~e_hs, ~e_vs, e_de, e_sof} || n_data !== e_data) begin
        errors++; $display("FAIL neg_pol_cycle i=%0d got %b %h want %b %h", i, {n_hs, n_vs, n_de, n_sof}, n_data, {~e_hs, ~e_vs, e_de, e_sof}, e_data);
      end
    end
    held = e_data;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pix = DW'($urandom);
      tick();
      checks++; if (n_hs !== 1'b1 || n_vs !== 1'b1) begin errors++; $display("FAIL disable_sync_neg got %b%b want 11", n_hs, n_vs); end
      checks++; if (hs !== 1'b0 || vs !== 1'b0) begin errors++; $display("FAIL disable_sync_pos got %b%b want 00", hs, vs); end
      checks++; if ({de, n_de, sof, uf, n_uf} !== 5'b0) begin errors++; $display("FAIL disable_strobes got %b want 00000", {de, n_de, sof, uf, n_uf}); end
      checks++; if (data !== held || n_data !== held) begin errors++; $display("FAIL disable_hold got %h/%h want %h", data, n_data, held); end
      checks++; if (n_ready !== 1'b0) begin errors++; $display("FAIL disable_ready got %b want 0", n_ready); end
    end
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      pix = DW'($urandom);
      tick();
      checks++;
      if ({n_hs, n_vs, n_de} !== {~e_hs, ~e_vs, e_de} || {hs, vs, de} !== {e_hs, e_vs, e_de}) begin
        errors++; $display("FAIL reenable_cycle i=%0d got %b %b want %b %b", i, {n_hs, n_vs, n_de}, {hs, vs, de}, {~e_hs, ~e_vs, e_de}, {e_hs, e_vs, e_de});
      end
    end
  endtask

  task automatic test_reset_mid();
    int target = VBEG * HT + HBEG + 3;
    en = 1'b1; mode = 2'd0; valid = 1'b1;
    for (int i = 0; i < FT && k != target; i++) begin
      pix = DW'($urandom);
      tick();
    end
    checks++; if (fcnt === 16'd0) begin errors++; $display("FAIL premid_fcnt got 0 want nonzero"); end
    rst = 1'b1;
    tick();
    checks++; if ({hs, vs, n_hs, n_vs} !== 4'b0011) begin errors++; $display("FAIL midrst_sync got %b want 0011", {hs, vs, n_hs, n_vs}); end
    checks++; if ({de, sof, uf} !== 3'b000) begin errors++; $display("FAIL midrst_strobes got %b want 000", {de, sof, uf}); end
    checks++; if (data !== '0) begin errors++; $display("FAIL midrst_data got %h want 0", data); end
    checks++; if (fcnt !== 16'd0 || n_fcnt !== 16'd0) begin errors++; $display("FAIL midrst_fcnt got %0d/%0d want 0", fcnt, n_fcnt); end
    rst = 1'b0;
    for (int i = 0; i < FT; i++) begin
      pix = DW'($urandom);
      tick();
      checks++;
      if ({hs, vs, de, sof, uf} !== {e_hs, e_vs, e_de, e_sof, e_uf} || data !== e_data || fcnt !== 16'(frames)) begin
        errors++; $display("FAIL postrst_cycle i=%0d got %b %h %0d want %b %h %0d", i, {hs, vs, de, sof, uf}, data, fcnt,
                           {e_hs, e_vs, e_de, e_sof, e_uf}, e_data, frames);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_underflow();
    test_patterns();
    test_disable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
